// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the Lab 6 multiplier
package mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } press_state_e;

  // 5 ms of stable level at 100 MHz
  localparam int DB_CYCLES_DEFAULT = 500_000;
  localparam int OP_WIDTH          = 4;

endpackage

// File: rtl/debouncer.sv
// rtl/debouncer.sv - two-flop synchronizer plus counter debouncer for one bit
module debouncer #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic level_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample matching the current level clears the count, so a bounce restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/mult_input_ctrl.sv
// rtl/mult_input_ctrl.sv - debounced Mult button to start pulse with operand capture
module mult_input_ctrl
  import mult_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int WIDTH     = OP_WIDTH
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             BTN,
  input  logic [WIDTH-1:0] A_SW,
  input  logic [WIDTH-1:0] B_SW,
  input  logic             BUSY,
  output logic             MULT,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             DROP
);

  logic             db_level, db_level_prev_q, db_rise;
  logic [WIDTH-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             mult_q, mult_d, drop_q, drop_d;
  press_state_e     state_q, state_d;

  debouncer #(.DB_CYCLES(DB_CYCLES)) u_btn_db (
    .clk_i  (clk),
    .rst_i  (RST),
    .din_i  (BTN),
    .level_o(db_level)
  );

  assign db_rise = db_level & ~db_level_prev_q;

  always_comb begin
    state_d = state_q;
    mult_d  = 1'b0;
    drop_d  = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (db_rise) begin
          state_d = HELD;
          if (BUSY) begin
            drop_d = 1'b1;
          end else begin
            mult_d = 1'b1;
            a_d    = a_s2_q;
            b_d    = b_s2_q;
          end
        end
      end
      HELD: begin
        if (!db_level) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      a_s1_q          <= '0;
      a_s2_q          <= '0;
      b_s1_q          <= '0;
      b_s2_q          <= '0;
      db_level_prev_q <= 1'b0;
      state_q         <= IDLE;
      mult_q          <= 1'b0;
      drop_q          <= 1'b0;
      a_q             <= '0;
      b_q             <= '0;
    end else begin
      a_s1_q          <= A_SW;
      a_s2_q          <= a_s1_q;
      b_s1_q          <= B_SW;
      b_s2_q          <= b_s1_q;
      db_level_prev_q <= db_level;
      state_q         <= state_d;
      mult_q          <= mult_d;
      drop_q          <= drop_d;
      a_q             <= a_d;
      b_q             <= b_d;
    end
  end

  assign MULT = mult_q;
  assign DROP = drop_q;
  assign A    = a_q;
  assign B    = b_q;

endmodule

// File: tb/tb_mult_input_ctrl.sv
// tb/tb_mult_input_ctrl.sv - scoreboard bench for mult_input_ctrl with DB_CYCLES=4
module tb_mult_input_ctrl;

  localparam int DB  = 4;
  localparam int LAT = DB + 3;
  localparam int K_MULT = 1;
  localparam int K_DROP = 2;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       BTN = 1'b0;
  logic [3:0] A_SW = 4'h0;
  logic [3:0] B_SW = 4'h0;
  logic       BUSY = 1'b0;
  logic       MULT, DROP;
  logic [3:0] A, B;

  typedef struct {
    int         kind;
    logic [3:0] a;
    logic [3:0] b;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [3:0] cur_a = 4'h0;
  logic [3:0] cur_b = 4'h0;

  mult_input_ctrl #(.DB_CYCLES(DB), .WIDTH(4)) dut (
    .clk (clk),
    .RST (RST),
    .BTN (BTN),
    .A_SW(A_SW),
    .B_SW(B_SW),
    .BUSY(BUSY),
    .MULT(MULT),
    .A   (A),
    .B   (B),
    .DROP(DROP)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!RST && (MULT || DROP)) begin
      check("excl", int'(MULT & DROP), 0);
      if (sbq.size() == 0) begin
        check("unexpected_out", int'({DROP, MULT}), 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("kind", int'({DROP, MULT}), e.kind);
        check("cycle", cyc, e.cyc);
        check("a", int'(A), int'(e.a));
        check("b", int'(B), int'(e.b));
      end
    end
  end

  task automatic press(input logic [3:0] a, input logic [3:0] b, input logic busy, input logic expect_out);
    exp_t e;
    @(posedge clk); #1;
    A_SW = a;
    B_SW = b;
    BUSY = busy;
    BTN  = 1'b1;
    if (expect_out) begin
      if (!busy) begin
        cur_a = a;
        cur_b = b;
      end
      e.kind = busy ? K_DROP : K_MULT;
      e.a    = cur_a;
      e.b    = cur_b;
      e.cyc  = cyc + LAT;
      sbq.push_back(e);
    end
  endtask

  task automatic set_btn(input logic v, input int hold);
    @(posedge clk); #1;
    BTN = v;
    repeat (hold - 1) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_mult", int'(MULT), 0);
    check("rst_drop", int'(DROP), 0);
    check("rst_a", int'(A), 0);
    check("rst_b", int'(B), 0);
    RST = 1'b0;
    repeat (3) @(posedge clk);

    press(4'h3, 4'h5, 1'b0, 1'b1);
    repeat (12) @(posedge clk);
    set_btn(1'b0, 15);

    A_SW = 4'h1; B_SW = 4'h2;
    for (int i = 0; i < 2; i++) begin
      set_btn(1'b1, 2);
      set_btn(1'b0, 2);
    end
    press(4'h1, 4'h2, 1'b0, 1'b1);
    repeat (12) @(posedge clk);
    set_btn(1'b0, 15);

    press(4'h6, 4'h7, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1 A_SW = 4'hF;
    repeat (40) @(posedge clk);
    #1;
    check("held_a", int'(A), 6);
    check("held_b", int'(B), 7);
    set_btn(1'b0, 15);

    press(4'h9, 4'h9, 1'b1, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    check("drop_a", int'(A), 6);
    check("drop_b", int'(B), 7);
    set_btn(1'b0, 15);
    BUSY = 1'b0;
    press(4'hC, 4'hD, 1'b0, 1'b1);
    repeat (12) @(posedge clk);
    set_btn(1'b0, 15);

    press(4'h2, 4'h4, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 RST = 1'b1;
    #1;
    check("midrst_mult", int'(MULT), 0);
    check("midrst_drop", int'(DROP), 0);
    check("midrst_a", int'(A), 0);
    check("midrst_b", int'(B), 0);
    cur_a = 4'h0;
    cur_b = 4'h0;
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;
    begin
      exp_t e;
      cur_a  = 4'h2;
      cur_b  = 4'h4;
      e.kind = K_MULT;
      e.a    = cur_a;
      e.b    = cur_b;
      e.cyc  = cyc + LAT;
      sbq.push_back(e);
    end
    repeat (12) @(posedge clk);
    set_btn(1'b0, 15);

    press(4'h5, 4'h6, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    set_btn(1'b0, 12);
    press(4'h7, 4'h8, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    set_btn(1'b0, 15);

    press(4'hA, 4'hB, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    set_btn(1'b0, 3);
    press(4'hE, 4'h1, 1'b0, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    check("short_gap_a", int'(A), 10);
    set_btn(1'b0, 20);

    check("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
